// File: rtl/int_reservation_station.sv
// Integer reservation station: holds dispatched ALU ops until both operands
// are available, snoops the CDB for missing operands, and issues the
// lowest-index ready entry to the integer ALU through a registered stage.
module int_reservation_station #(
   parameter int DEPTH      = 4,
   parameter int TAG_WIDTH  = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dispatch_en,
   input  logic [3:0]            dispatch_op,
   input  logic [TAG_WIDTH-1:0]  dispatch_dest_tag,
   input  logic                  dispatch_rs1_valid,
   input  logic [TAG_WIDTH-1:0]  dispatch_rs1_tag,
   input  logic [DATA_WIDTH-1:0] dispatch_rs1_data,
   input  logic                  dispatch_rs2_valid,
   input  logic [TAG_WIDTH-1:0]  dispatch_rs2_tag,
   input  logic [DATA_WIDTH-1:0] dispatch_rs2_data,
   input  logic                  CDB_valid,
   input  logic                  CDB_branch,
   input  logic                  CDB_branch_taken,
   input  logic [TAG_WIDTH-1:0]  CDB_tag,
   input  logic [DATA_WIDTH-1:0] CDB_data,
   input  logic                  issue_int,
   output logic                  ready_int,
   output logic                  rs_full,
   output logic                  exec_valid,
   output logic [3:0]            exec_op,
   output logic [TAG_WIDTH-1:0]  exec_tag,
   output logic [DATA_WIDTH-1:0] exec_rs1_data,
   output logic [DATA_WIDTH-1:0] exec_rs2_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]      busy_q, busy_d;
   logic [DEPTH-1:0]      rs1_valid_q, rs1_valid_d;
   logic [DEPTH-1:0]      rs2_valid_q, rs2_valid_d;
   logic [3:0]            op_q        [DEPTH];
   logic [3:0]            op_d        [DEPTH];
   logic [TAG_WIDTH-1:0]  dest_tag_q  [DEPTH];
   logic [TAG_WIDTH-1:0]  dest_tag_d  [DEPTH];
   logic [TAG_WIDTH-1:0]  rs1_tag_q   [DEPTH];
   logic [TAG_WIDTH-1:0]  rs1_tag_d   [DEPTH];
   logic [TAG_WIDTH-1:0]  rs2_tag_q   [DEPTH];
   logic [TAG_WIDTH-1:0]  rs2_tag_d   [DEPTH];
   logic [DATA_WIDTH-1:0] rs1_data_q  [DEPTH];
   logic [DATA_WIDTH-1:0] rs1_data_d  [DEPTH];
   logic [DATA_WIDTH-1:0] rs2_data_q  [DEPTH];
   logic [DATA_WIDTH-1:0] rs2_data_d  [DEPTH];

   logic                  exec_valid_q, exec_valid_d;
   logic [3:0]            exec_op_q, exec_op_d;
   logic [TAG_WIDTH-1:0]  exec_tag_q, exec_tag_d;
   logic [DATA_WIDTH-1:0] exec_rs1_data_q, exec_rs1_data_d;
   logic [DATA_WIDTH-1:0] exec_rs2_data_q, exec_rs2_data_d;

   logic [DEPTH-1:0]      entry_ready;
   logic [IDX_W-1:0]      sel_idx;
   logic [IDX_W-1:0]      free_idx;
   logic                  issue_fire;
   logic                  dispatch_fire;
   logic                  flush;

   // Status flags look only at registered entry state.
   assign entry_ready   = busy_q & rs1_valid_q & rs2_valid_q;
   assign ready_int     = |entry_ready;
   assign rs_full       = &busy_q;
   assign issue_fire    = issue_int & ready_int;
   assign dispatch_fire = dispatch_en & ~rs_full;
   assign flush         = CDB_branch & CDB_branch_taken;

   // Lowest-index ready entry for issue and lowest-index free entry for
   // allocation; both use pre-edge state so a freed slot is not reused.
   always_comb begin
      sel_idx  = '0;
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (entry_ready[i]) sel_idx = IDX_W'(i);
         if (!busy_q[i])     free_idx = IDX_W'(i);
      end
   end

   // Next-state: flush wins, otherwise snoop, issue and dispatch together.
   always_comb begin
      busy_d          = busy_q;
      rs1_valid_d     = rs1_valid_q;
      rs2_valid_d     = rs2_valid_q;
      op_d            = op_q;
      dest_tag_d      = dest_tag_q;
      rs1_tag_d       = rs1_tag_q;
      rs2_tag_d       = rs2_tag_q;
      rs1_data_d      = rs1_data_q;
      rs2_data_d      = rs2_data_q;
      exec_valid_d    = 1'b0;
      exec_op_d       = exec_op_q;
      exec_tag_d      = exec_tag_q;
      exec_rs1_data_d = exec_rs1_data_q;
      exec_rs2_data_d = exec_rs2_data_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CDB_valid && busy_q[i] && !rs1_valid_q[i] && (rs1_tag_q[i] == CDB_tag)) begin
               rs1_valid_d[i] = 1'b1;
               rs1_data_d[i]  = CDB_data;
            end
            if (CDB_valid && busy_q[i] && !rs2_valid_q[i] && (rs2_tag_q[i] == CDB_tag)) begin
               rs2_valid_d[i] = 1'b1;
               rs2_data_d[i]  = CDB_data;
            end
         end
         if (issue_fire) begin
            busy_d[sel_idx] = 1'b0;
            exec_valid_d    = 1'b1;
            exec_op_d       = op_q[sel_idx];
            exec_tag_d      = dest_tag_q[sel_idx];
            exec_rs1_data_d = rs1_data_q[sel_idx];
            exec_rs2_data_d = rs2_data_q[sel_idx];
         end
         if (dispatch_fire) begin
            busy_d[free_idx]      = 1'b1;
            op_d[free_idx]        = dispatch_op;
            dest_tag_d[free_idx]  = dispatch_dest_tag;
            rs1_tag_d[free_idx]   = dispatch_rs1_tag;
            rs2_tag_d[free_idx]   = dispatch_rs2_tag;
            rs1_valid_d[free_idx] = dispatch_rs1_valid |
                                    (CDB_valid && (dispatch_rs1_tag == CDB_tag));
            rs2_valid_d[free_idx] = dispatch_rs2_valid |
                                    (CDB_valid && (dispatch_rs2_tag == CDB_tag));
            rs1_data_d[free_idx]  = dispatch_rs1_valid ? dispatch_rs1_data : CDB_data;
            rs2_data_d[free_idx]  = dispatch_rs2_valid ? dispatch_rs2_data : CDB_data;
         end
      end
   end

   // Control and exec registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_q          <= '0;
         rs1_valid_q     <= '0;
         rs2_valid_q     <= '0;
         exec_valid_q    <= 1'b0;
         exec_op_q       <= '0;
         exec_tag_q      <= '0;
         exec_rs1_data_q <= '0;
         exec_rs2_data_q <= '0;
      end else begin
         busy_q          <= busy_d;
         rs1_valid_q     <= rs1_valid_d;
         rs2_valid_q     <= rs2_valid_d;
         exec_valid_q    <= exec_valid_d;
         exec_op_q       <= exec_op_d;
         exec_tag_q      <= exec_tag_d;
         exec_rs1_data_q <= exec_rs1_data_d;
         exec_rs2_data_q <= exec_rs2_data_d;
      end
   end

   // Entry payload is qualified by busy/valid bits, so it needs no reset.
   always_ff @(posedge clk) begin
      op_q       <= op_d;
      dest_tag_q <= dest_tag_d;
      rs1_tag_q  <= rs1_tag_d;
      rs2_tag_q  <= rs2_tag_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
   end

   assign exec_valid    = exec_valid_q;
   assign exec_op       = exec_op_q;
   assign exec_tag      = exec_tag_q;
   assign exec_rs1_data = exec_rs1_data_q;
   assign exec_rs2_data = exec_rs2_data_q;

endmodule

// File: tb/tb_int_reservation_station.sv
// Bench for int_reservation_station: directed scenarios followed by random
// traffic, all compared against a rule-level model of the station.
module tb_int_reservation_station;

   logic        clk = 1'b0;
   logic        reset;
   logic        dispatch_en;
   logic [3:0]  dispatch_op;
   logic [5:0]  dispatch_dest_tag;
   logic        dispatch_rs1_valid, dispatch_rs2_valid;
   logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag;
   logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
   logic        CDB_valid, CDB_branch, CDB_branch_taken;
   logic [5:0]  CDB_tag;
   logic [31:0] CDB_data;
   logic        issue_int;
   logic        ready_int, rs_full, exec_valid;
   logic [3:0]  exec_op;
   logic [5:0]  exec_tag;
   logic [31:0] exec_rs1_data, exec_rs2_data;

   int errors = 0;
   int checks = 0;

   int_reservation_station #(.DEPTH(4), .TAG_WIDTH(6), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .dispatch_en(dispatch_en), .dispatch_op(dispatch_op),
      .dispatch_dest_tag(dispatch_dest_tag),
      .dispatch_rs1_valid(dispatch_rs1_valid), .dispatch_rs2_valid(dispatch_rs2_valid),
      .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
      .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
      .CDB_valid(CDB_valid), .CDB_branch(CDB_branch), .CDB_branch_taken(CDB_branch_taken),
      .CDB_tag(CDB_tag), .CDB_data(CDB_data), .issue_int(issue_int),
      .ready_int(ready_int), .rs_full(rs_full), .exec_valid(exec_valid),
      .exec_op(exec_op), .exec_tag(exec_tag),
      .exec_rs1_data(exec_rs1_data), .exec_rs2_data(exec_rs2_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          busy;
      logic [3:0]  op;
      logic [5:0]  dest;
      bit          v1;
      logic [5:0]  t1;
      logic [31:0] d1;
      bit          v2;
      logic [5:0]  t2;
      logic [31:0] d2;
   } ent_t;

   ent_t        m [4];
   bit          m_xv;
   logic [3:0]  m_xop;
   logic [5:0]  m_xtag;
   logic [31:0] m_x1, m_x2;
   bit          known = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_ready();
      for (int i = 0; i < 4; i++)
         if (m[i].busy && m[i].v1 && m[i].v2) return i;
      return -1;
   endfunction

   function automatic int first_free();
      for (int i = 0; i < 4; i++)
         if (!m[i].busy) return i;
      return -1;
   endfunction

   // Apply one clock edge's worth of the station's rules to the model.
   task automatic model_step();
      ent_t nxt [4];
      int   s, f;
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            m[i].busy = 0; m[i].v1 = 0; m[i].v2 = 0;
         end
         m_xv = 0; m_xop = '0; m_xtag = '0; m_x1 = '0; m_x2 = '0;
         known = 1'b1;
         return;
      end
      if (!known) return;
      if (CDB_branch && CDB_branch_taken) begin
         for (int i = 0; i < 4; i++) m[i].busy = 0;
         m_xv = 0;
         return;
      end
      nxt = m;
      s = first_ready();
      f = first_free();
      for (int i = 0; i < 4; i++) begin
         if (m[i].busy && CDB_valid && !m[i].v1 && m[i].t1 == CDB_tag) begin
            nxt[i].v1 = 1; nxt[i].d1 = CDB_data;
         end
         if (m[i].busy && CDB_valid && !m[i].v2 && m[i].t2 == CDB_tag) begin
            nxt[i].v2 = 1; nxt[i].d2 = CDB_data;
         end
      end
      m_xv = 0;
      if (issue_int && s >= 0) begin
         m_xv = 1; m_xop = m[s].op; m_xtag = m[s].dest; m_x1 = m[s].d1; m_x2 = m[s].d2;
         nxt[s].busy = 0;
      end
      if (dispatch_en && f >= 0) begin
         nxt[f].busy = 1;
         nxt[f].op   = dispatch_op;
         nxt[f].dest = dispatch_dest_tag;
         nxt[f].t1   = dispatch_rs1_tag;
         nxt[f].t2   = dispatch_rs2_tag;
         if (dispatch_rs1_valid) begin nxt[f].v1 = 1; nxt[f].d1 = dispatch_rs1_data; end
         else if (CDB_valid && dispatch_rs1_tag == CDB_tag) begin nxt[f].v1 = 1; nxt[f].d1 = CDB_data; end
         else nxt[f].v1 = 0;
         if (dispatch_rs2_valid) begin nxt[f].v2 = 1; nxt[f].d2 = dispatch_rs2_data; end
         else if (CDB_valid && dispatch_rs2_tag == CDB_tag) begin nxt[f].v2 = 1; nxt[f].d2 = CDB_data; end
         else nxt[f].v2 = 0;
      end
      m = nxt;
   endtask

   // Check status flags, advance the model, clock the DUT, then check exec.
   task automatic tick();
      if (known) begin
         chk("ready_int", {31'd0, ready_int}, {31'd0, first_ready() >= 0});
         chk("rs_full", {31'd0, rs_full}, {31'd0, first_free() < 0});
      end
      model_step();
      @(posedge clk);
      #1;
      if (known) begin
         chk("exec_valid", {31'd0, exec_valid}, {31'd0, m_xv});
         chk("exec_op", {28'd0, exec_op}, {28'd0, m_xop});
         chk("exec_tag", {26'd0, exec_tag}, {26'd0, m_xtag});
         chk("exec_rs1_data", exec_rs1_data, m_x1);
         chk("exec_rs2_data", exec_rs2_data, m_x2);
      end
   endtask

   task automatic clear();
      dispatch_en = 0; dispatch_op = '0; dispatch_dest_tag = '0;
      dispatch_rs1_valid = 0; dispatch_rs1_tag = '0; dispatch_rs1_data = '0;
      dispatch_rs2_valid = 0; dispatch_rs2_tag = '0; dispatch_rs2_data = '0;
      CDB_valid = 0; CDB_branch = 0; CDB_branch_taken = 0; CDB_tag = '0; CDB_data = '0;
      issue_int = 0;
   endtask

   task automatic disp(input logic [3:0] op, input logic [5:0] dest,
                       input logic v1, input logic [5:0] t1, input logic [31:0] d1,
                       input logic v2, input logic [5:0] t2, input logic [31:0] d2);
      dispatch_en = 1; dispatch_op = op; dispatch_dest_tag = dest;
      dispatch_rs1_valid = v1; dispatch_rs1_tag = t1; dispatch_rs1_data = d1;
      dispatch_rs2_valid = v2; dispatch_rs2_tag = t2; dispatch_rs2_data = d2;
   endtask

   task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
      CDB_valid = 1; CDB_tag = tag; CDB_data = data;
   endtask

   initial begin
      clear();
      reset = 0;
      tick();
      tick();
      chk("reset_ready", {31'd0, ready_int}, 32'd0);
      chk("reset_full", {31'd0, rs_full}, 32'd0);
      chk("reset_exec_valid", {31'd0, exec_valid}, 32'd0);
      reset = 1;

      // Both operands valid at dispatch, issued the next cycle.
      disp(4'h1, 6'd5, 1, 6'd0, 32'd10, 1, 6'd0, 32'd20);
      tick(); clear();
      chk("d1_ready", {31'd0, ready_int}, 32'd1);
      issue_int = 1;
      tick(); clear();
      chk("d1_exec_valid", {31'd0, exec_valid}, 32'd1);
      chk("d1_exec_rs1", exec_rs1_data, 32'd10);
      chk("d1_exec_rs2", exec_rs2_data, 32'd20);
      chk("d1_exec_tag", {26'd0, exec_tag}, 32'd5);
      chk("d1_ready_after", {31'd0, ready_int}, 32'd0);
      tick();
      chk("d1_exec_pulse", {31'd0, exec_valid}, 32'd0);

      // Operand resolved by a later CDB broadcast.
      disp(4'h2, 6'd6, 0, 6'd9, 32'd0, 1, 6'd0, 32'd3);
      tick(); clear();
      tick();
      cdb(6'd9, 32'hDEAD);
      chk("d2_not_ready", {31'd0, ready_int}, 32'd0);
      tick(); clear();
      chk("d2_ready", {31'd0, ready_int}, 32'd1);
      issue_int = 1;
      tick(); clear();
      chk("d2_exec_rs1", exec_rs1_data, 32'hDEAD);
      chk("d2_exec_rs2", exec_rs2_data, 32'd3);

      // Dispatch bypass from the CDB in the same cycle.
      disp(4'h3, 6'd8, 0, 6'd7, 32'd0, 1, 6'd0, 32'd1);
      cdb(6'd7, 32'd99);
      tick(); clear();
      chk("d3_ready", {31'd0, ready_int}, 32'd1);
      issue_int = 1;
      tick(); clear();
      chk("d3_exec_rs1", exec_rs1_data, 32'd99);

      // Fill, ignored fifth dispatch, resolve and issue entry 2.
      for (int k = 0; k < 4; k++) begin
         disp(4'h4, 6'(10 + k), 0, 6'(20 + k), 32'd0, 1, 6'd0, 32'(k));
         tick(); clear();
      end
      chk("d4_full", {31'd0, rs_full}, 32'd1);
      disp(4'h5, 6'd30, 0, 6'd24, 32'd0, 0, 6'd25, 32'd0);
      tick(); clear();
      chk("d4_full_still", {31'd0, rs_full}, 32'd1);
      cdb(6'd22, 32'h222);
      tick(); clear();
      issue_int = 1;
      tick(); clear();
      chk("d4_not_full", {31'd0, rs_full}, 32'd0);
      chk("d4_exec_tag", {26'd0, exec_tag}, 32'd12);
      chk("d4_exec_rs1", exec_rs1_data, 32'h222);
      for (int k = 0; k < 4; k++) begin
         if (k == 2) continue;
         cdb(6'(20 + k), 32'(16'hA000 + k));
         tick(); clear();
         issue_int = 1;
         tick(); clear();
         chk("d4_rest_tag", {26'd0, exec_tag}, 32'(10 + k));
         chk("d4_rest_rs2", exec_rs2_data, 32'(k));
      end

      // Taken-branch flush with a simultaneous dispatch.
      for (int k = 0; k < 3; k++) begin
         disp(4'h6, 6'(40 + k), 0, 6'(40 + k), 32'd0, 1, 6'd0, 32'd0);
         tick(); clear();
      end
      disp(4'h7, 6'd50, 1, 6'd0, 32'd1, 1, 6'd0, 32'd2);
      CDB_branch = 1; CDB_branch_taken = 1;
      tick(); clear();
      chk("d5_full", {31'd0, rs_full}, 32'd0);
      chk("d5_ready", {31'd0, ready_int}, 32'd0);
      chk("d5_exec_valid", {31'd0, exec_valid}, 32'd0);
      cdb(6'd40, 32'd5);
      tick(); clear();
      chk("d5_stays_empty", {31'd0, ready_int}, 32'd0);

      // Reset while two entries are ready and issue is requested.
      disp(4'h8, 6'd60, 1, 6'd0, 32'd7, 1, 6'd0, 32'd8);
      tick(); clear();
      disp(4'h9, 6'd61, 1, 6'd0, 32'd9, 1, 6'd0, 32'd10);
      tick(); clear();
      issue_int = 1;
      reset = 0;
      tick(); clear();
      reset = 1;
      chk("d6_exec_valid", {31'd0, exec_valid}, 32'd0);
      chk("d6_exec_op", {28'd0, exec_op}, 32'd0);
      chk("d6_exec_tag", {26'd0, exec_tag}, 32'd0);
      chk("d6_exec_rs1", exec_rs1_data, 32'd0);
      chk("d6_ready", {31'd0, ready_int}, 32'd0);
      chk("d6_full", {31'd0, rs_full}, 32'd0);
      tick();
      chk("d6_no_pulse", {31'd0, exec_valid}, 32'd0);

      // Random traffic with a narrow tag space to provoke collisions.
      for (int n = 0; n < 1500; n++) begin
         reset              = ($urandom_range(0, 199) != 0);
         dispatch_en        = ($urandom_range(0, 1) == 1);
         dispatch_op        = 4'($urandom);
         dispatch_dest_tag  = 6'($urandom);
         dispatch_rs1_valid = ($urandom_range(0, 2) == 0);
         dispatch_rs1_tag   = 6'($urandom_range(0, 7));
         dispatch_rs1_data  = $urandom;
         dispatch_rs2_valid = ($urandom_range(0, 2) == 0);
         dispatch_rs2_tag   = 6'($urandom_range(0, 7));
         dispatch_rs2_data  = $urandom;
         CDB_valid          = ($urandom_range(0, 1) == 1);
         CDB_tag            = 6'($urandom_range(0, 7));
         CDB_data           = $urandom;
         CDB_branch         = ($urandom_range(0, 24) == 0);
         CDB_branch_taken   = ($urandom_range(0, 1) == 1);
         issue_int          = ($urandom_range(0, 4) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
